// File: rtl/uart_rx_sniffer_if.sv
// Byte-stream handshake between the UART sniffer and its consumer.
//   data  : head byte of the receive FIFO, meaningful only while valid is high
//   valid : the FIFO holds at least one byte
//   ready : the consumer takes the head byte on a clock edge where valid && ready
// The master modport is the producer (the sniffer) and the slave modport is the consumer.
interface uart_rx_sniffer_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/uart_rx_sniffer.sv
// 8N1 UART receiver with a show-ahead byte FIFO.
// It watches a serial transmit line and turns the frames into a valid/ready byte stream.
// It flags newline bytes for console-line parsing.
// It also reports framing errors (stop bit low) and overrun errors (byte dropped, FIFO full).
//
// Ports
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   rx_i        : serial line, idle high, asynchronous to clk
//   clr_err_i   : one-cycle pulse that clears frame_err_o and overrun_o
//   out_if      : byte stream (master side): data, valid out; ready in
//   frame_err_o : sticky, a stop bit was sampled low
//   overrun_o   : sticky, a received byte was dropped because the FIFO was full
//   byte_cnt_o  : number of bytes pushed into the FIFO, wraps at 16 bits
//   newline_o   : one-cycle pulse on the edge that pushes 8'h0A
module uart_rx_sniffer #(
  parameter int unsigned CLK_FREQ_HZ = 25_000_000,
  parameter int unsigned BAUD_RATE   = 781250,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx_i,
  input  logic                     clr_err_i,
  uart_rx_sniffer_if.master        out_if,
  output logic                     frame_err_o,
  output logic                     overrun_o,
  output logic              [15:0] byte_cnt_o,
  output logic                     newline_o
);

  // Clocks per bit.
  localparam int unsigned CPB   = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned CntW  = (CPB > 2) ? $clog2(CPB) : 2;
  localparam int unsigned AddrW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PtrW  = AddrW + 1;

  localparam logic [CntW-1:0] CntBit  = CntW'(CPB - 1);
  // Half a bit time puts every later sample near the middle of its bit.
  localparam logic [CntW-1:0] CntHalf = CntW'(CPB / 2 - 1);

  if (CPB < 4) begin : g_bad_cpb
    $fatal(1, "uart_rx_sniffer: CLK_FREQ_HZ/BAUD_RATE must be at least 4");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "uart_rx_sniffer: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  // ---------------------------------------------------------------------------
  // Input synchronizer. Both flops reset to the idle line level, so that reset
  // by itself never looks like a start bit.
  // ---------------------------------------------------------------------------
  logic rx_meta_q;
  logic rxs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rxs_q     <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame receiver FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      sr_q, sr_d;
  logic            push;
  logic            frame_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    sr_d      = sr_q;
    push      = 1'b0;
    frame_set = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!rxs_q) begin
          state_d = StStart;
          cnt_d   = CntHalf;
        end
      end

      StStart: begin
        if (cnt_q == '0) begin
          if (rxs_q) begin
            // The line went high again before mid-start: this is a glitch, not a frame.
            state_d = StIdle;
          end else begin
            state_d = StData;
            cnt_d   = CntBit;
            idx_d   = 3'd0;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StData: begin
        if (cnt_q == '0) begin
          sr_d  = {rxs_q, sr_q[7:1]};
          cnt_d = CntBit;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StStop: begin
        if (cnt_q == '0) begin
          if (rxs_q) begin
            // Go back to IDLE at mid-stop so that the next start edge is detected
            // even when frames are sent back to back.
            push    = 1'b1;
            state_d = StIdle;
          end else begin
            frame_set = 1'b1;
            state_d   = StBreak;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StBreak: begin
        // Wait for the line to go high, so that a held-low line gives only one error.
        if (rxs_q) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Show-ahead FIFO. The pointers have one extra wrap bit to tell full from empty.
  // ---------------------------------------------------------------------------
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic            empty;
  logic            full;
  logic            pop;
  logic            push_ok;
  logic            overrun_set;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AddrW{1'b0}}});
  assign pop   = !empty && out_if.ready;

  // A pop in the same cycle makes room, so a push into a full FIFO is kept.
  assign push_ok     = push && (!full || pop);
  assign overrun_set = push && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= sr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  assign out_if.valid = !empty;
  // Force data to zero when the FIFO is empty, so that unwritten RAM never reaches the pins.
  assign out_if.data  = empty ? 8'h00 : mem_q[rd_ptr_q[AddrW-1:0]];

  // ---------------------------------------------------------------------------
  // Status: byte counter, newline strobe, sticky error flags
  // ---------------------------------------------------------------------------
  logic [15:0] byte_cnt_q;
  logic        newline_q;
  logic        frame_err_q;
  logic        overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q  <= '0;
      newline_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (push_ok) begin
        byte_cnt_q <= byte_cnt_q + 16'd1;
      end
      newline_q   <= push_ok && (sr_q == 8'h0A);
      // If a new error and a clear arrive in the same cycle, the flag stays set.
      frame_err_q <= frame_set || (frame_err_q && !clr_err_i);
      overrun_q   <= overrun_set || (overrun_q && !clr_err_i);
    end
  end

  assign byte_cnt_o  = byte_cnt_q;
  assign newline_o   = newline_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx_sniffer.sv
`timescale 1ns/1ps
module tb_uart_rx_sniffer;
  localparam int unsigned Cpb   = 32;
  localparam int unsigned Depth = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_i;
  logic        clr_err_i;
  logic        frame_err_o;
  logic        overrun_o;
  logic [15:0] byte_cnt_o;
  logic        newline_o;

  uart_rx_sniffer_if bus();

  uart_rx_sniffer #(
    .CLK_FREQ_HZ(25_000_000),
    .BAUD_RATE  (781250),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_i       (rx_i),
    .clr_err_i  (clr_err_i),
    .out_if     (bus.master),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o),
    .byte_cnt_o (byte_cnt_o),
    .newline_o  (newline_o)
  );

  always #20 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the bytes the consumer should see, plus the expected status.
  logic [7:0] exp_q[$];
  int         model_cnt = 0;
  int         nl_exp = 0;
  int         nl_seen = 0;
  bit         ferr_m = 0;
  bit         ovr_m = 0;

  bit rand_ready = 0;
  bit ready_val = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bytes are received in order. A good frame adds a byte only if the FIFO still has room.
  task automatic model_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      ferr_m = 1;
    end else if (exp_q.size() < Depth) begin
      exp_q.push_back(b);
      model_cnt++;
      if (b == 8'h0A) nl_exp++;
    end else begin
      ovr_m = 1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good);
    rx_i = 1'b0;
    tick(Cpb);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      tick(Cpb);
    end
    model_frame(b, good);
    rx_i = good;
    tick(Cpb);
    rx_i = 1'b1;
    if (!good) tick(Cpb);
  endtask

  task automatic wait_drain;
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      tick(1);
      n++;
    end
    check("drain_remaining", exp_q.size(), 0);
    tick(2);
  endtask

  task automatic clear_errors;
    clr_err_i = 1'b1;
    tick(1);
    clr_err_i = 1'b0;
    ferr_m = 0;
    ovr_m = 0;
    check("frame_err_cleared", frame_err_o, 0);
    check("overrun_cleared", overrun_o, 0);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_byte_cnt"}, byte_cnt_o, model_cnt[15:0]);
    check({tag, "_frame_err"}, frame_err_o, ferr_m);
    check({tag, "_overrun"}, overrun_o, ovr_m);
    check({tag, "_newlines"}, nl_seen, nl_exp);
  endtask

  // Ready driver.
  initial begin
    forever begin
      bus.ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
      @(posedge clk);
      #1;
    end
  end

  // Monitor: it samples mid-cycle, where the values are those the next rising edge will see.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (newline_o === 1'b1) nl_seen++;
        if (bus.valid === 1'b1 && bus.ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected actual=%0h required=none", bus.data);
          end else begin
            check("pop_data", bus.data, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int lat;
    rst_n = 1'b0;
    rx_i = 1'b1;
    clr_err_i = 1'b0;
    tick(3);
    check("reset_valid", bus.valid, 0);
    check("reset_data", bus.data, 0);
    check("reset_byte_cnt", byte_cnt_o, 0);
    check("reset_flags", {frame_err_o, overrun_o, newline_o}, 0);
    rst_n = 1'b1;
    tick(5);

    // 1: a single byte, and its latency from the start edge.
    ready_val = 1;
    lat = 0;
    fork
      send_byte(8'h55, 1);
      begin
        while (bus.valid !== 1'b1 && lat < 400) begin
          tick(1);
          lat++;
        end
      end
    join
    check("valid_latency_window", 32'(lat >= 303 && lat <= 310), 1);
    wait_drain();
    check_status("t1");

    // 2: a short low glitch must not start a frame.
    rx_i = 1'b0;
    tick(8);
    rx_i = 1'b1;
    tick(100);
    check("glitch_valid", bus.valid, 0);
    check_status("t2");

    // 3: a bad stop bit gives a framing error and pushes nothing.
    send_byte(8'hA5, 0);
    tick(10);
    check("t3_valid", bus.valid, 0);
    check_status("t3");
    clear_errors();

    // 4: overflow with the consumer stalled, then drain.
    ready_val = 0;
    for (int i = 0; i < 17; i++) send_byte(8'(i), 1);
    tick(5);
    check_status("t4");
    check("t4_valid", bus.valid, 1);
    check("t4_head", bus.data, 8'h00);
    ready_val = 1;
    wait_drain();
    clear_errors();

    // 5: "OK\n" sent back to back.
    send_byte(8'h4F, 1);
    send_byte(8'h4B, 1);
    send_byte(8'h0A, 1);
    wait_drain();
    check_status("t5");

    // Random traffic with a randomly stalling consumer.
    rand_ready = 1;
    for (int i = 0; i < 24; i++) begin
      send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 9) != 0);
      tick($urandom_range(0, 40));
    end
    rand_ready = 0;
    ready_val = 1;
    wait_drain();
    check_status("rand");
    clear_errors();

    // 6: reset in the middle of the data bits of 0x3C.
    rx_i = 1'b0;
    tick(Cpb);
    rx_i = 1'b0;
    tick(Cpb + 10);
    rst_n = 1'b0;
    rx_i = 1'b1;
    tick(3);
    check("t6_rst_valid", bus.valid, 0);
    check("t6_rst_data", bus.data, 0);
    check("t6_rst_byte_cnt", byte_cnt_o, 0);
    check("t6_rst_flags", {frame_err_o, overrun_o, newline_o}, 0);
    exp_q.delete();
    model_cnt = 0;
    rst_n = 1'b1;
    tick(10);
    send_byte(8'h81, 1);
    wait_drain();
    check("t6_byte_cnt", byte_cnt_o, 1);
    check("t6_frame_err", frame_err_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop if the run goes on far too long.
  initial begin
    #(40 * 90000);
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
